// File: rtl/prr_io_responder.sv
// One CGRA partial-reconfiguration region as seen from the global buffer:
// a small config register file plus a g2f -> FIFO -> f2g stream loopback with optional add transform.
module prr_io_responder #(
    parameter int PRR_ID     = 0,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              cfg_wr_en,
    input  logic [ADDR_W-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_rd_en,
    input  logic [ADDR_W-1:0] cfg_rd_addr,
    output logic [DATA_W-1:0] cfg_rd_data,
    input  logic              io1_g2io,
    input  logic [15:0]       io16_g2io,
    output logic              io1_io2g,
    output logic [15:0]       io16_io2g
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-9:0] PRR_SEL   = (ADDR_W-8)'(PRR_ID);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]        OFF_CTRL  = 8'h00;
    localparam logic [7:0]        OFF_CONST = 8'h04;
    localparam logic [7:0]        OFF_STAT  = 8'h08;
    localparam logic [7:0]        OFF_INC   = 8'h0C;
    localparam logic [7:0]        OFF_OUTC  = 8'h10;
    localparam logic [7:0]        OFF_CLEAR = 8'h14;

    typedef enum logic {
        ST_FILL,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic               mode_q, mode_d;
    logic [3:0]         thresh_q, thresh_d;
    logic [15:0]        const_q, const_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        in_cnt_q, in_cnt_d;
    logic [31:0]        out_cnt_q, out_cnt_d;
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [15:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               io1_q, io1_d;
    logic [15:0]        io16_q, io16_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic        wr_hit, rd_hit, clear, full, empty, ready, draining;
    logic        push_req, push, pop, drop;
    logic [3:0]  thresh_eff;
    logic [31:0] rd_word;
    logic [15:0] head;
    logic        unused_wr_hi;

    assign unused_wr_hi = ^cfg_wr_data[DATA_W-1:16];

    assign wr_hit = cfg_wr_en && (cfg_wr_addr[ADDR_W-1:8] == PRR_SEL);
    assign rd_hit = cfg_rd_en && (cfg_rd_addr[ADDR_W-1:8] == PRR_SEL);
    assign clear  = wr_hit && (cfg_wr_addr[7:0] == OFF_CLEAR) && cfg_wr_data[0];

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign thresh_eff = (thresh_q == 4'd0) ? 4'd1 : thresh_q;
    assign ready      = en_q && (32'(count_q) >= 32'(thresh_eff));
    assign head       = mem_q[rd_ptr_q];

    // FILL pops in the same cycle the threshold is met, so a lone word costs only the FIFO and output registers.
    assign draining = (state_q == ST_DRAIN) ? en_q : ready;
    assign pop      = draining && !stall && !empty && !clear;
    assign push_req = io1_g2io && en_q;
    assign push     = push_req && (!full || pop) && !clear;
    assign drop     = push_req && full && !pop;

    always_comb begin
        rd_word = 32'h0;
        case (cfg_rd_addr[7:0])
            OFF_CTRL:  rd_word = {24'h0, thresh_q, 2'b00, mode_q, en_q};
            OFF_CONST: rd_word = {16'h0, const_q};
            OFF_STAT:  rd_word = {16'h0, 8'(count_q), 5'h0, full, empty, ovf_q};
            OFF_INC:   rd_word = in_cnt_q;
            OFF_OUTC:  rd_word = out_cnt_q;
            default:   rd_word = 32'h0;
        endcase
        rd_data_d = rd_hit ? DATA_W'(rd_word) : '0;
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        const_d  = const_q;
        if (wr_hit && cfg_wr_addr[7:0] == OFF_CTRL) begin
            en_d     = cfg_wr_data[0];
            mode_d   = cfg_wr_data[1];
            thresh_d = cfg_wr_data[7:4];
        end
        if (wr_hit && cfg_wr_addr[7:0] == OFF_CONST) begin
            const_d = cfg_wr_data[15:0];
        end
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ovf_d     = ovf_q || drop;
        io1_d     = pop;
        io16_d    = io16_q;
        if (push) begin
            mem_d[wr_ptr_q] = io16_g2io;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            in_cnt_d        = in_cnt_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            out_cnt_d = out_cnt_q + 32'd1;
            io16_d    = mode_q ? 16'(head + const_q) : head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            in_cnt_d  = 32'h0;
            out_cnt_d = 32'h0;
            ovf_d     = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (ready) state_d = ST_DRAIN;
            ST_DRAIN: if (!en_q || (empty && !push)) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
        if (clear) state_d = ST_FILL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FILL;
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            thresh_q  <= 4'h0;
            const_q   <= 16'h0;
            ovf_q     <= 1'b0;
            in_cnt_q  <= 32'h0;
            out_cnt_q <= 32'h0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            io1_q     <= 1'b0;
            io16_q    <= 16'h0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            thresh_q  <= thresh_d;
            const_q   <= const_d;
            ovf_q     <= ovf_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            io1_q     <= io1_d;
            io16_q    <= io16_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign cfg_rd_data = rd_data_q;
    assign io1_io2g    = io1_q;
    assign io16_io2g   = io16_q;

endmodule
